// File: rtl/mac_out_pack_pkg.sv
// Shared definitions for the MAC output packing stage: conv word width,
// packer state encoding and the lane-count width helper.
package mac_out_pack_pkg;

  localparam int MAC_DW = 16;

  typedef enum logic {
    FILL       = 1'b0,
    FLUSH_PEND = 1'b1
  } pack_state_e;

  // Width needed to hold a lane count of 1..lanes inclusive.
  function automatic int nlanes_width(input int lanes);
    return $clog2(lanes) + 1;
  endfunction

endpackage

// File: rtl/mac_out_fifo.sv
// Synchronous FIFO between the packer and the output buffer path.
// The head word reads as zero while empty so downstream never sees stale data.
module mac_out_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mac_out_pack.sv
// Packs LANES stage-5 conv results per word into a FIFO and stalls the MAC
// pipeline via o_inhibit. States: FILL = normal packing, FLUSH_PEND = partial word waiting for FIFO space.
module mac_out_pack
  import mac_out_pack_pkg::*;
#(
  parameter int LANES = 4,
  parameter int DEPTH = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_valid,
  input  logic [MAC_DW-1:0]                i_conv,
  input  logic                             i_flush,
  output logic                             o_inhibit,
  output logic                             o_valid,
  output logic [MAC_DW*LANES-1:0]          o_data,
  output logic [nlanes_width(LANES)-1:0]   o_nlanes,
  input  logic                             i_ready
);

  localparam int LW  = $clog2(LANES);
  localparam int NLW = nlanes_width(LANES);
  localparam int DW  = MAC_DW * LANES;
  localparam int FW  = NLW + DW;
  localparam int CW  = $clog2(DEPTH) + 1;

  pack_state_e      r_state;
  logic [DW-1:0]    r_pack;
  logic [LW-1:0]    r_lane;
  logic             r_inhibit;

  logic             w_take;
  logic [DW-1:0]    w_pack_wr;
  logic [NLW-1:0]   w_fill;
  logic             w_complete;
  logic             w_flush_req;
  logic             w_push;
  logic [FW-1:0]    w_push_data;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CW-1:0]    w_count;
  logic [CW-1:0]    w_count_nxt;
  logic [FW-1:0]    w_fifo_q;
  pack_state_e      w_state_nxt;
  logic [DW-1:0]    w_pack_nxt;
  logic [LW-1:0]    w_lane_nxt;

  always_comb begin
    w_take      = i_valid & ~r_inhibit;
    w_pack_wr   = r_pack;
    if (w_take) w_pack_wr[r_lane*MAC_DW +: MAC_DW] = i_conv;
    w_fill      = NLW'(r_lane) + NLW'(w_take);
    w_complete  = w_take && (r_lane == LW'(LANES-1));
    w_flush_req = i_flush && (w_fill != '0);

    w_push      = 1'b0;
    w_push_data = {w_fill, w_pack_wr};
    w_state_nxt = r_state;
    w_pack_nxt  = w_pack_wr;
    w_lane_nxt  = w_fill[LW-1:0];

    case (r_state)
      FILL: begin
        // Completion never coincides with a full FIFO: o_inhibit blocks that transfer.
        if (w_complete || (w_flush_req && !w_full)) begin
          w_push     = 1'b1;
          w_pack_nxt = '0;
          w_lane_nxt = '0;
        end else if (w_flush_req) begin
          w_state_nxt = FLUSH_PEND;
        end
      end
      FLUSH_PEND: begin
        w_push_data = {NLW'(r_lane), r_pack};
        if (!w_full) begin
          w_push      = 1'b1;
          w_pack_nxt  = '0;
          w_lane_nxt  = '0;
          w_state_nxt = FILL;
        end
      end
      default: w_state_nxt = FILL;
    endcase

    w_pop       = ~w_empty & i_ready;
    w_count_nxt = w_count + CW'(w_push) - CW'(w_pop);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= FILL;
      r_pack    <= '0;
      r_lane    <= '0;
      r_inhibit <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pack    <= w_pack_nxt;
      r_lane    <= w_lane_nxt;
      // Registered from next-state values so it tracks the FIFO/lane registers exactly.
      r_inhibit <= (w_state_nxt == FLUSH_PEND) ||
                   ((w_count_nxt == CW'(DEPTH)) && (w_lane_nxt == LW'(LANES-1)));
    end
  end

  mac_out_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_wdata (w_push_data),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_q),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign o_inhibit = r_inhibit;
  assign o_valid   = ~w_empty;
  assign o_data    = w_fifo_q[DW-1:0];
  assign o_nlanes  = w_fifo_q[FW-1:DW];

endmodule

// File: tb/tb_mac_out_pack.sv
// Scoreboard bench for mac_out_pack: a queue-based packing model predicts
// words and stall behaviour; a monitor compares every handshake.
module tb_mac_out_pack;

  localparam int LANES = 4;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [15:0] i_conv = '0;
  logic        i_flush = 1'b0;
  logic        i_ready = 1'b0;
  logic        o_inhibit;
  logic        o_valid;
  logic [63:0] o_data;
  logic [2:0]  o_nlanes;

  int n_pass = 0;
  int n_total = 0;
  int n_words = 0;
  int last_nl = 0;

  // Model state: filled lane values, pending flush flag, FIFO occupancy.
  int          m_lanes[$];
  bit          m_pend = 0;
  int          m_cnt = 0;
  logic [66:0] exp_q[$];

  mac_out_pack #(.LANES(LANES), .DEPTH(DEPTH)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_valid   (i_valid),
    .i_conv    (i_conv),
    .i_flush   (i_flush),
    .o_inhibit (o_inhibit),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_nlanes  (o_nlanes),
    .i_ready   (i_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic bit model_inh();
    return m_pend || (m_cnt == DEPTH && m_lanes.size() == LANES - 1);
  endfunction

  function automatic void model_emit();
    logic [63:0] w;
    w = '0;
    for (int i = 0; i < m_lanes.size(); i++) w[16*i +: 16] = 16'(m_lanes[i]);
    exp_q.push_back({3'(m_lanes.size()), w});
    m_lanes.delete();
  endfunction

  // Reference model: applies the transfer, completion and flush rules per edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lanes.delete();
      exp_q.delete();
      m_pend = 0;
      m_cnt  = 0;
    end else begin
      bit inh, pop, pushed;
      inh    = model_inh();
      pop    = (m_cnt > 0) && i_ready;
      pushed = 0;
      if (!m_pend) begin
        if (i_valid && !inh) m_lanes.push_back(int'(i_conv));
        if (m_lanes.size() == LANES) begin
          model_emit();
          pushed = 1;
        end else if (i_flush && m_lanes.size() > 0) begin
          if (m_cnt < DEPTH) begin
            model_emit();
            pushed = 1;
          end else m_pend = 1;
        end
      end else if (m_cnt < DEPTH) begin
        model_emit();
        pushed = 1;
        m_pend = 0;
      end
      m_cnt = m_cnt + int'(pushed) - int'(pop);
    end
  end

  // Monitor: checks stall/valid every cycle and pops the scoreboard on handshakes.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("inhibit", 128'(o_inhibit), 128'(model_inh()));
      chk("valid", 128'(o_valid), 128'(m_cnt > 0));
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL word_unexpected: got %0h expected no word", {o_nlanes, o_data});
        end else begin
          chk("word", 128'({o_nlanes, o_data}), 128'(exp_q.pop_front()));
        end
        n_words++;
        last_nl = int'(o_nlanes);
      end
    end
  end

  task automatic stream(input int n, input logic [15:0] base, input int max_cyc,
                        input bit flush_last, output int taken);
    taken = 0;
    for (int c = 0; c < max_cyc && taken < n; c++) begin
      i_valid = 1'b1;
      i_conv  = 16'(base + 16'(taken));
      @(negedge clk);
      if (!o_inhibit) begin
        if (flush_last && taken == n - 1) i_flush = 1'b1;
        taken++;
      end
      @(posedge clk); #1;
      i_flush = 1'b0;
    end
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_flush();
    i_flush = 1'b1;
    @(posedge clk); #1;
    i_flush = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int tk, w0;
    bit held;
    #1;
    chk("rst_valid", 128'(o_valid), 0);
    chk("rst_inhibit", 128'(o_inhibit), 0);
    chk("rst_data", 128'(o_data), 0);
    chk("rst_nlanes", 128'(o_nlanes), 0);
    #21 rst_n = 1'b1;
    @(posedge clk); #1;

    // Continuous stream, two full words.
    i_ready = 1'b1;
    w0 = n_words;
    stream(8, 16'h0001, 20, 0, tk);
    idle(4);
    chk("s1_words", 128'(n_words - w0), 2);

    // Partial word via flush, then next result lands in lane 0.
    w0 = n_words;
    stream(3, 16'h000A, 10, 0, tk);
    pulse_flush();
    stream(4, 16'h0011, 10, 0, tk);
    idle(4);
    chk("s2_words", 128'(n_words - w0), 2);

    // Backpressure: 24 results offered with downstream stalled.
    i_ready = 1'b0;
    w0 = n_words;
    stream(24, 16'h0100, 30, 0, tk);
    chk("s3_taken", 128'(tk), 19);
    chk("s3_inhibit", 128'(o_inhibit), 1);
    i_ready = 1'b1;
    stream(5, 16'h0113, 40, 0, tk);
    chk("s3_rest", 128'(tk), 5);
    idle(10);
    chk("s3_words", 128'(n_words - w0), 6);

    // FIFO full plus flush with two lanes filled.
    i_ready = 1'b0;
    w0 = n_words;
    stream(18, 16'h0200, 30, 0, tk);
    chk("s4_taken", 128'(tk), 18);
    pulse_flush();
    @(negedge clk);
    chk("s4_pend_inhibit", 128'(o_inhibit), 1);
    @(posedge clk); #1;
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
    idle(2);
    chk("s4_release", 128'(o_inhibit), 0);
    i_ready = 1'b1;
    idle(10);
    chk("s4_words", 128'(n_words - w0), 5);
    chk("s4_last_nl", 128'(last_nl), 2);

    // Flush coinciding with completion, then an empty flush.
    w0 = n_words;
    stream(4, 16'h0300, 10, 1, tk);
    pulse_flush();
    idle(5);
    chk("s5_words", 128'(n_words - w0), 1);
    chk("s5_last_nl", 128'(last_nl), 4);

    // Reset mid-word with two words queued.
    i_ready = 1'b0;
    stream(10, 16'h0400, 20, 0, tk);
    #2 rst_n = 1'b0;
    #1;
    chk("r_valid", 128'(o_valid), 0);
    chk("r_inhibit", 128'(o_inhibit), 0);
    chk("r_data", 128'(o_data), 0);
    chk("r_nlanes", 128'(o_nlanes), 0);
    idle(2);
    rst_n = 1'b1;
    i_ready = 1'b1;
    w0 = n_words;
    stream(4, 16'h0500, 10, 0, tk);
    idle(4);
    chk("r_words", 128'(n_words - w0), 1);
    chk("r_last_nl", 128'(last_nl), 4);

    // Random traffic with stage-5 hold semantics.
    held = 0;
    for (int c = 0; c < 600; c++) begin
      if (!held) begin
        i_valid = ($urandom_range(0, 3) != 0);
        i_conv  = 16'($urandom);
      end
      i_flush = ($urandom_range(0, 9) == 0);
      i_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      held = i_valid && o_inhibit;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    i_flush = 1'b0;
    i_ready = 1'b1;
    idle(3);
    pulse_flush();
    idle(12);
    chk("drain_empty", 128'(exp_q.size()), 0);
    chk("drain_valid", 128'(o_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mac_out_pack.md
# mac_out_pack

Output packing stage placed directly after MAC stage 5. It consumes the 16-bit conv results and valid flag that stage 5 produces, and packs LANES consecutive results into one wide word. The words go into a small FIFO toward the output buffer, and the block throttles the MAC pipeline through its inhibit port. The block owns the backpressure boundary between the MAC pipeline and the output memory path.

## Interface
- LANES, 4, results packed per output word (power of two, ≥2)
- DEPTH, 4, FIFO depth in packed words (power of two, ≥2)
- i_clk  in  1  clock; single clock domain
- i_rst_n  in  1  asynchronous, active-low reset
- i_valid  in  1  stage-5 o_valid
- i_conv  in  16  stage-5 o_conv
- i_flush  in  1  single-cycle pulse: emit partially filled word
- o_inhibit  out  1  drives the MAC pipeline inhibit (stall); reset 0
- o_valid  out  1  FIFO head valid; reset 0
- o_data  out  16*LANES  packed word, lane 0 in bits [15:0]; reset 0
- o_nlanes  out  clog2(LANES)+1  number of valid lanes in o_data (1..LANES); reset 0
- i_ready  in  1  downstream accepts o_data when o_valid & i_ready

## Operation
- Transfer rule: a result is taken at a rising edge iff i_valid & ~o_inhibit.
  - When o_inhibit is high, stage 5 holds its registers, so the held value must not be counted twice.
- Pack register: holds up to LANES results. lane_cnt runs 0..LANES-1. Each transfer writes lane[lane_cnt] and increments lane_cnt.
- Word completion: a transfer into lane LANES-1 pushes {lanes, nlanes=LANES} into the FIFO at the same edge. lane_cnt wraps to 0 and the pack register clears to 0.
- Flush: on i_flush, if lane_cnt>0 or a transfer occurs in that cycle, push the partial word. Unused lanes are 0 and nlanes equals the filled count, including that cycle's transfer.
  - Flush with nothing filled is a no-op.
  - Flush coinciding with natural completion pushes exactly one word, with nlanes=LANES.
- States: FILL (normal) and FLUSH_PEND.
  - If a flush cannot push because the FIFO is full, the block enters FLUSH_PEND and holds o_inhibit high.
  - It pushes on the first edge with FIFO space, then returns to FILL.
  - Further i_flush pulses while in FLUSH_PEND are ignored.
- o_inhibit is high when either of these holds:
  - the FIFO count is DEPTH and lane_cnt is LANES-1 (the next transfer would overflow);
  - the state is FLUSH_PEND.
- o_inhibit is a function of registered state only. There is no combinational path from i_valid, i_flush or i_ready.
- FIFO: standard synchronous FIFO. Pop when o_valid & i_ready. Simultaneous push and pop while full is legal only in the case where o_inhibit was low, which by construction means no push occurs. A push and pop together at other counts leave the count unchanged.
- Data is never dropped and never duplicated. The FIFO never overflows or underflows.

## Timing
- Latency: the result completing a word at edge t appears on o_data/o_valid right after edge t, so it is visible in cycle t+1.
- o_inhibit asserts in the cycle after the state that causes it. It deasserts in the cycle after the pop that frees space. A pop at full therefore costs one stall cycle, which is accepted.
- Reset mid-operation clears everything at once: pack register, lane_cnt, FIFO pointers and count, and state returns to FILL. All outputs go to 0 asynchronously, with no pending flush retained.
- Throughput: one result per cycle sustained while i_ready stays high.

## Structure
- Shared MAC package holds:
  - MAC_DW=16 (conv word width);
  - a state enum {FILL, FLUSH_PEND};
  - a function computing the nlanes width from LANES.
- Sub-module: mac_out_fifo, a parameterised synchronous FIFO (width, depth) with full, empty and count outputs. The pack, flush and inhibit logic stays in mac_out_pack.

## Test plan
- Stream 0x0001..0x0008 continuously with i_ready=1 and LANES=4 -> two words, 0x0004_0003_0002_0001 and 0x0008_0007_0006_0005, each with nlanes=4. o_inhibit stays 0.
- Three results 0xA, 0xB, 0xC followed by an i_flush pulse -> one word 0x0000_000C_000B_000A with nlanes=3. The next result lands in lane 0.
- i_ready=0 with a stream of 24 results at DEPTH=4 -> o_inhibit rises once 4 words are queued and lane_cnt=3. Exactly 19 results are taken, with no duplicate while inhibit holds i_conv stable. Raising i_ready drains all words in order with no loss.
- FIFO full plus i_flush with 2 lanes filled -> FLUSH_PEND and o_inhibit=1. The partial word (nlanes=2) is pushed one edge after the first pop, then o_inhibit drops.
- i_flush on the same edge as the 4th transfer -> exactly one word with nlanes=4. A flush with lane_cnt=0 and no transfer -> no push.
- Assert i_rst_n low mid-word with 2 queued words -> o_valid, o_inhibit, o_data and o_nlanes read 0 immediately. After release, the first 4 results form a fresh word.
